gate_drive_p16: RTL and testbench
=================================

Name: gate_drive_p16

Overview:
- Sits directly downstream of the 16-phase signal generator. Consumes its 16-subsample parallel drive word and one-hot cycle-end word.
- Produces complementary high-side/low-side 16-subsample gate words with programmable dead time.
- Applies cycle-aligned burst (interrupter) gating with a burst-length limit, post-burst holdoff and a latched fault shutdown.
- Outputs feed the per-channel serializers.

Parameters:
- MAX_DEAD, 16, largest dead time in subsamples; dead_time input is clamped to this.
- CNT_W, 16, width of burst_len, holdoff and the internal cycle counters.

Ports:
- p_clock  in  1  fast parallel clock; one 16-subsample word per edge.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  16  drive word from the generator; bit 0 is the earliest subsample.
- cycle_end  in  16  one-hot cycle-end marker; bit c set means the period ends at subsample c.
- enable  in  1  burst request, level sensitive.
- burst_len  in  CNT_W  maximum cycles per burst; 0 means unlimited.
- holdoff  in  CNT_W  cycle_end events to wait after a burst before re-arming.
- dead_time  in  5  dead time in subsamples; clamped to MAX_DEAD.
- fault  in  1  shutdown request.
- fault_clear  in  1  clears a latched fault.
- hi_out  out  16  high-side gate word.
- lo_out  out  16  low-side gate word.
- running  out  1  FSM is in RUN.
- fault_latched  out  1  FSM is in FAULT.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM to IDLE, history invalid, counters 0. Reset mid-burst zeroes hi_out/lo_out on the very next edge.
- Latency: exactly 1 p_clock. Outputs are registered; no combinational input-to-output path.
- Stream s is the concatenation of the previous sig_in word (16-bit history register) and the current word. Dead time D is latched from min(dead_time, MAX_DEAD) only while in IDLE.
- Raw drive per subsample k: hi_raw[k] = 1 when s was high at k-D..k inclusive; lo_raw[k] = 1 when s was low at k-D..k. D = 0 gives hi = s, lo = ~s.
- History before the first post-reset word counts as neither high nor low.
- hi_raw and lo_raw are never both 1 at the same k. Checker: hi_out & lo_out == 0 always.
- Gate mask g[k] is set by the FSM. Outputs: hi_out = hi_raw & g, lo_out = lo_raw & g.
- If cycle_end has more than one bit set, only the lowest set bit c counts. cycle_end == 0 means no event this word.
- FSM states: IDLE, RUN, HOLD, FAULT.
- IDLE: g = 0.
  - With enable = 1 and an event at c: g[c+1..15] = 1, cycle counter = 0, go to RUN.
  - c = 15 yields no active bits this word.
- RUN: each event at c increments the cycle counter n. The burst ends at that event when enable = 0 or (burst_len != 0 and n+1 == burst_len). On end:
  - g[0..c] = 1, g[c+1..15] = 0.
  - Go to HOLD, or to IDLE if holdoff == 0.
  - Otherwise the word is fully gated on (g = all ones).
  - Dropping enable never truncates a cycle mid-period.
- HOLD: g = 0. Each event increments the holdoff counter; at count == holdoff, go to IDLE. enable is ignored in HOLD.
- FAULT: entered from any state when fault = 1, overriding everything in the same edge.
  - Outputs 0 on the next edge; fault_latched = 1.
  - Leaves to IDLE only when fault_clear = 1 and fault = 0.
  - Simultaneous fault and fault_clear: stay in FAULT.
- Counters saturate at all-ones; they never wrap.

Test Plan:
- Steady run, D = 0, enable = 1, burst_len = 0, period 32 (sig_in alternating 0xFFFF/0x0000, cycle_end bit 15 every second word) -> after entry, hi_out tracks sig_in and lo_out = ~sig_in, both delayed 1 clock; running = 1.
- Dead time: D = 3, sig_in rising at subsample 8 (0xFF00 after 0x0000) -> hi_out = 0xF800, lo_out = 0x00FF; the falling edge mirrors with 3 zero subsamples in lo_out. Assert hi & lo == 0 every cycle.
- Burst entry and limit: enable rises, event at c = 5, burst_len = 3 -> first active word g = 0xFFC0. The burst ends at the 3rd event at its c with g = low bits 0..c. running drops the following cycle.
- Holdoff: holdoff = 2, enable held 1 -> outputs 0 for exactly 2 events after burst end; re-entry at the 3rd event.
- Fault mid-burst: fault pulse in RUN -> next outputs 0, fault_latched = 1. Outputs stay 0 with enable = 1. fault_clear returns to IDLE; the next event restarts the burst.
- Reset mid-burst with D = 4 -> outputs 0 next edge. The first post-reset active word produces no hi/lo bits in subsamples 0..3.

Source files
------------

// File: rtl/gate_drive_p16_if.sv
`default_nettype none
// ============================================================================
//  Module   : gate_drive_p16_if
//  Purpose  : Drive-word, burst-control and gate-word bundle between the
//             16-phase generator / controller and the gate driver.
//  Revision : 1.0  initial release
// ============================================================================
interface gate_drive_p16_if #(
   parameter int CNT_W = 16
) ();
   logic [15:0]      sig_in;
   logic [15:0]      cycle_end;
   logic             enable;
   logic [CNT_W-1:0] burst_len;
   logic [CNT_W-1:0] holdoff;
   logic [4:0]       dead_time;
   logic             fault;
   logic             fault_clear;
   logic [15:0]      hi_out;
   logic [15:0]      lo_out;
   logic             running;
   logic             fault_latched;

   // Upstream side: drives the stream and controls, observes the gate words
   modport master (
      output sig_in, cycle_end, enable, burst_len, holdoff, dead_time,
             fault, fault_clear,
      input  hi_out, lo_out, running, fault_latched
   );

   // Gate driver side
   modport slave (
      input  sig_in, cycle_end, enable, burst_len, holdoff, dead_time,
             fault, fault_clear,
      output hi_out, lo_out, running, fault_latched
   );
endinterface
`default_nettype wire

// File: rtl/gate_drive_p16.sv
`default_nettype none
// ============================================================================
//  Module   : gate_drive_p16
//  Purpose  : Complementary hi/lo 16-subsample gate words with dead time,
//             cycle-aligned burst gating, post-burst holdoff and latched
//             fault shutdown. One registered stage, no comb in->out path.
//  Revision : 1.0  initial release
// ============================================================================
module gate_drive_p16 #(
   parameter int MAX_DEAD = 16,   // must not exceed 16: the look-back spans one history word
   parameter int CNT_W    = 16
) (
   input  wire logic       p_clock,
   input  wire logic       reset,
   gate_drive_p16_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam logic [4:0]       c_max_dead = 5'(MAX_DEAD);
   localparam logic [CNT_W-1:0] c_cnt_max  = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [15:0]      hist_q;
   logic             hist_valid_q;
   logic [4:0]       dead_q;
   logic [15:0]      hi_q, lo_q;
   logic             running_q, fault_q;

   logic [4:0]       dead_clamp, dead_eff;
   logic [31:0]      s_hi, s_lo;
   logic [15:0]      hi_raw, lo_raw;
   logic [15:0]      gate_d;
   logic             ev;
   logic [15:0]      ev_lsb, low_mask;
   logic [CNT_W-1:0] run_inc, hold_inc;

   // In IDLE the live setting applies so the entry word already uses it;
   // from RUN onwards the value captured during IDLE is held.
   assign dead_clamp = (bus.dead_time > c_max_dead) ? c_max_dead : bus.dead_time;
   assign dead_eff   = (state_q == ST_IDLE) ? dead_clamp : dead_q;

   // Dead-time qualified raw drive: a side is on only when the stream has
   // held its level for D+1 subsamples; invalid history matches neither level
   always_comb begin
      s_hi = {bus.sig_in,  hist_valid_q ? hist_q  : 16'h0000};
      s_lo = {~bus.sig_in, hist_valid_q ? ~hist_q : 16'h0000};
      for (int k = 0; k < 16; k++) begin
         hi_raw[k] = 1'b1;
         lo_raw[k] = 1'b1;
         for (int d = 0; d <= MAX_DEAD; d++) begin
            if (d <= int'(dead_eff)) begin
               hi_raw[k] = hi_raw[k] & s_hi[5'(16 + k - d)];
               lo_raw[k] = lo_raw[k] & s_lo[5'(16 + k - d)];
            end
         end
      end
   end

   // Only the lowest set cycle_end bit counts; low_mask covers bits 0..c
   assign ev       = |bus.cycle_end;
   assign ev_lsb   = bus.cycle_end & (~bus.cycle_end + 16'd1);
   assign low_mask = ev_lsb | (ev_lsb - 16'd1);
   assign run_inc  = (run_cnt_q  == c_cnt_max) ? run_cnt_q  : run_cnt_q  + 1'b1;
   assign hold_inc = (hold_cnt_q == c_cnt_max) ? hold_cnt_q : hold_cnt_q + 1'b1;

   // Burst FSM next state and per-subsample gate mask; fault overrides all
   always_comb begin
      state_d    = state_q;
      run_cnt_d  = run_cnt_q;
      hold_cnt_d = hold_cnt_q;
      gate_d     = 16'h0000;
      if (bus.fault) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.enable && ev) begin
                  gate_d    = ~low_mask;
                  run_cnt_d = '0;
                  state_d   = ST_RUN;
               end
            end
            ST_RUN: begin
               gate_d = 16'hFFFF;
               if (ev) begin
                  if (!bus.enable || (bus.burst_len != '0 && run_inc == bus.burst_len)) begin
                     // finish the current period, then stop on its boundary
                     gate_d     = low_mask;
                     hold_cnt_d = '0;
                     state_d    = (bus.holdoff == '0) ? ST_IDLE : ST_HOLD;
                  end else begin
                     run_cnt_d = run_inc;
                  end
               end
            end
            ST_HOLD: begin
               if (ev) begin
                  hold_cnt_d = hold_inc;
                  if (hold_inc == bus.holdoff) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_FAULT: begin
               if (bus.fault_clear) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, history and registered outputs
   always_ff @(posedge p_clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         run_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         hist_q       <= 16'h0000;
         hist_valid_q <= 1'b0;
         dead_q       <= 5'd0;
         hi_q         <= 16'h0000;
         lo_q         <= 16'h0000;
         running_q    <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_cnt_q    <= run_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         hist_q       <= bus.sig_in;
         hist_valid_q <= 1'b1;
         if (state_q == ST_IDLE) begin
            dead_q <= dead_clamp;
         end
         hi_q         <= hi_raw & gate_d;
         lo_q         <= lo_raw & gate_d;
         running_q    <= (state_d == ST_RUN);
         fault_q      <= (state_d == ST_FAULT);
      end
   end

   assign bus.hi_out        = hi_q;
   assign bus.lo_out        = lo_q;
   assign bus.running       = running_q;
   assign bus.fault_latched = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_drive_p16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_drive_p16
//  Purpose  : Directed vectors for gate_drive_p16; expected words queued at
//             drive time and popped by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gate_drive_p16;

   typedef struct {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        run;
      logic        flt;
      int          id;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   vec_id;
   logic started;
   exp_t exp_q[$];

   gate_drive_p16_if #(.CNT_W(16)) bus ();

   gate_drive_p16 #(
      .MAX_DEAD (16),
      .CNT_W    (16)
   ) dut (
      .p_clock (clk),
      .reset   (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue the response due after the coming edge, then move to next negedge
   task automatic tick(input logic [15:0] eh, input logic [15:0] el,
                       input logic er, input logic ef);
      exp_t e;
      e.hi  = eh;
      e.lo  = el;
      e.run = er;
      e.flt = ef;
      e.id  = vec_id;
      vec_id++;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic drive(input logic [15:0] s, input logic [15:0] ce, input logic en);
      bus.sig_in    = s;
      bus.cycle_end = ce;
      bus.enable    = en;
   endtask

   // Monitor: overlap invariant every cycle, scoreboard pop per output word
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (started) begin
         checks++;
         if ((bus.hi_out & bus.lo_out) != 16'h0000) begin
            errors++;
            $display("FAIL overlap: hi=%h lo=%h share bits", bus.hi_out, bus.lo_out);
         end
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.hi_out !== e.hi || bus.lo_out !== e.lo ||
             bus.running !== e.run || bus.fault_latched !== e.flt) begin
            errors++;
            $display("FAIL vec%0d: got hi=%h lo=%h run=%b flt=%b, want hi=%h lo=%h run=%b flt=%b",
                     e.id, bus.hi_out, bus.lo_out, bus.running, bus.fault_latched,
                     e.hi, e.lo, e.run, e.flt);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      errors  = 0;
      checks  = 0;
      vec_id  = 0;
      started = 1'b0;
      rst     = 1'b1;
      drive(16'h0000, 16'h0000, 1'b0);
      bus.burst_len   = 16'd0;
      bus.holdoff     = 16'd0;
      bus.dead_time   = 5'd0;
      bus.fault       = 1'b0;
      bus.fault_clear = 1'b0;
      @(negedge clk);
      started = 1'b1;

      // reset state
      tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      rst = 1'b0;

      // steady run, D=0, period 32, entry at c=15 gives an empty first word
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      drive(16'h0000, 16'h8000, 1'b1); tick(16'h0000, 16'h0000, 1'b1, 1'b0);
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      drive(16'h0000, 16'h8000, 1'b1); tick(16'h0000, 16'hFFFF, 1'b1, 1'b0);
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      drive(16'h0000, 16'h8000, 1'b1); tick(16'h0000, 16'hFFFF, 1'b1, 1'b0);
      // enable drop mid-period: period completes, burst ends on its event
      drive(16'hFFFF, 16'h0000, 1'b0); tick(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      drive(16'h0000, 16'h8000, 1'b0); tick(16'h0000, 16'hFFFF, 1'b0, 1'b0);

      // dead time D=3
      bus.dead_time = 5'd3;
      drive(16'h0000, 16'h0000, 1'b0); tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      drive(16'h0000, 16'h8000, 1'b1); tick(16'h0000, 16'h0000, 1'b1, 1'b0);
      drive(16'hFF00, 16'h0000, 1'b1); tick(16'hF800, 16'h00FF, 1'b1, 1'b0);
      drive(16'h0000, 16'h0000, 1'b1); tick(16'h0000, 16'hFFF8, 1'b1, 1'b0);
      drive(16'hFF00, 16'h0000, 1'b1); tick(16'hF800, 16'h00FF, 1'b1, 1'b0);
      // end at c=4: only subsamples 0..4 gated
      drive(16'h0000, 16'h0010, 1'b0); tick(16'h0000, 16'h0018, 1'b0, 1'b0);

      // burst limit 3 with holdoff 2; constant-high stream makes hi_out == gate
      bus.dead_time = 5'd0;
      bus.burst_len = 16'd3;
      bus.holdoff   = 16'd2;
      drive(16'hFFFF, 16'h0000, 1'b0); tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'hFFC0, 16'h0000, 1'b1, 1'b0);
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'h003F, 16'h0000, 1'b0, 1'b0);
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      // re-entry on the third event; multi-bit cycle_end uses lowest bit (5)
      drive(16'hFFFF, 16'h0820, 1'b1); tick(16'hFFC0, 16'h0000, 1'b1, 1'b0);

      // fault mid-burst
      bus.fault = 1'b1;
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b1);
      bus.fault = 1'b0;
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b1);
      bus.fault = 1'b1;
      bus.fault_clear = 1'b1;
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b1);
      bus.fault = 1'b0;
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      bus.fault_clear = 1'b0;
      bus.dead_time   = 5'd4;
      drive(16'hFFFF, 16'h0020, 1'b1); tick(16'hFFC0, 16'h0000, 1'b1, 1'b0);
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'hFFFF, 16'h0000, 1'b1, 1'b0);

      // reset mid-burst, D=4: first post-reset word has no valid history
      rst = 1'b1;
      drive(16'hFFFF, 16'h0000, 1'b1); tick(16'h0000, 16'h0000, 1'b0, 1'b0);
      rst = 1'b0;
      drive(16'hFFFF, 16'h0001, 1'b1); tick(16'hFFF0, 16'h0000, 1'b1, 1'b0);
      drive(16'h0000, 16'h0000, 1'b1); tick(16'h0000, 16'hFFF0, 1'b1, 1'b0);

      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected words never compared, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
